pkt_check: RTL

//  Downstream consumer for the packet FIFO read side. Drives b_rdy and accepts
//  the vld/sop/eop/8-bit byte stream. Checks each packet's framing, length and

---
 rtl/pkt_check_if.sv | 26 ++
 rtl/pkt_check.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_check_if.sv
// -----------------------------------------------------------------------------
// pkt_check_if
//   Byte-stream handshake between the packet FIFO read side (master) and the
//   pkt_check consumer (slave). A beat transfers on a clock where
//   din_vld & b_rdy are both high.
//
//   din_vld  master->slave  beat valid
//   din_sop  master->slave  first beat of packet
//   din      master->slave  payload byte (DATA_W bits)
//   din_eop  master->slave  last beat of packet
//   b_rdy    slave->master  consumer ready
// -----------------------------------------------------------------------------
interface pkt_check_if #(
   parameter int unsigned DATA_W = 8
);
   logic              din_vld;
   logic              din_sop;
   logic [DATA_W-1:0] din;
   logic              din_eop;
   logic              b_rdy;

   modport master (output din_vld, output din_sop, output din, output din_eop,
                   input  b_rdy);
   modport slave  (input  din_vld, input  din_sop, input  din, input  din_eop,
                   output b_rdy);
endinterface

// File: rtl/pkt_check.sv
// -----------------------------------------------------------------------------
// pkt_check
//   Consumer for the packet FIFO read side. Accepts the vld/sop/eop byte
//   stream, checks framing, packet length (PKT_LEN beats) and incrementing
//   payload (byte k == k mod 2^DATA_W), and reports per-packet ok/err pulses,
//   the last error code and saturating good/error packet counters.
//
//   Optional build macro PKT_CHK_THROTTLE_EN: enables a free-running phase
//   counter that holds b_rdy low for RDY_OFF of every RDY_PERIOD cycles.
//
//   Ports
//     clk, rst     clock, asynchronous active-high reset
//     en           consumer enable (b_rdy forced low when 0)
//     bus          pkt_check_if.slave: din_vld/din_sop/din/din_eop in, b_rdy out
//     pkt_ok       1-cycle pulse, good packet completed
//     pkt_err      1-cycle pulse, bad packet completed or orphan beat
//     err_code     last error: 0 none,1 NOSOP,2 DUPSOP,3 DATA,4 SHORT,5 LONG
//     pkt_cnt      good packets, saturating
//     err_cnt      pkt_err pulses, saturating
//     busy         FSM not IDLE
// -----------------------------------------------------------------------------
module pkt_check #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PKT_LEN    = 191,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RDY_PERIOD = 8,
   parameter int unsigned RDY_OFF    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   pkt_check_if.slave       bus,
   output logic             pkt_ok,
   output logic             pkt_err,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy
);
   localparam int unsigned      IDX_W = $clog2(PKT_LEN + 1);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(PKT_LEN - 1);

   if (PKT_LEN < 2 || RDY_OFF >= RDY_PERIOD) begin : g_bad_cfg
      $error("pkt_check: PKT_LEN must be >= 2 and RDY_OFF < RDY_PERIOD");
   end

   typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
   typedef enum logic [2:0] {
      E_NONE, E_NOSOP, E_DUPSOP, E_DATA, E_SHORT, E_LONG
   } err_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   err_t              code_q, code_d;
   logic              ok_q, ok_d;
   logic              err_q, err_d;
   logic              b_rdy_q, b_rdy_d;
   logic              busy_q;
   logic [CNT_W-1:0]  pkt_cnt_q, err_cnt_q;

   logic              acc;
   logic [DATA_W-1:0] exp_byte;

   assign acc      = bus.din_vld & b_rdy_q;
   assign exp_byte = DATA_W'(idx_q);

   // -------------------------------------------------------------------------
   // Ready generation
   // -------------------------------------------------------------------------
`ifdef PKT_CHK_THROTTLE_EN
   localparam int unsigned PH_W = (RDY_PERIOD > 1) ? $clog2(RDY_PERIOD) : 1;
   logic [PH_W-1:0] phase_q, phase_d;

   always_comb begin
      phase_d = (phase_q == PH_W'(RDY_PERIOD - 1)) ? '0 : phase_q + 1'b1;
      b_rdy_d = en & (32'(phase_q) < (RDY_PERIOD - RDY_OFF));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end
`else
   always_comb b_rdy_d = en;
`endif

   // -------------------------------------------------------------------------
   // Packet FSM
   // -------------------------------------------------------------------------
   // Every accepted sop starts a fresh packet from any state; the state only
   // decides what happens to the packet being cut short (DUPSOP code from
   // RECV, an error pulse from DRAIN).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      code_d  = code_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      if (acc) begin
         if (bus.din_sop) begin
            idx_d = IDX_W'(1);
            if (bus.din_eop) begin
               state_d = IDLE;
               err_d   = 1'b1;
               code_d  = (bus.din != '0) ? E_DATA : E_SHORT;
            end else if (bus.din != '0) begin
               state_d = DRAIN;
               code_d  = E_DATA;
            end else begin
               state_d = RECV;
            end
            if (state_q == RECV)  code_d = E_DUPSOP;
            if (state_q == DRAIN) err_d  = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  err_d  = 1'b1;
                  code_d = E_NOSOP;
               end
               RECV: begin
                  if (bus.din != exp_byte) begin
                     code_d = E_DATA;
                     if (bus.din_eop) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                     end else begin
                        state_d = DRAIN;
                     end
                  end else if (bus.din_eop) begin
                     state_d = IDLE;
                     if (idx_q == LAST) begin
                        ok_d = 1'b1;
                     end else begin
                        err_d  = 1'b1;
                        code_d = E_SHORT;
                     end
                  end else if (idx_q == LAST) begin
                     state_d = DRAIN;
                     code_d  = E_LONG;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
               DRAIN: begin
                  if (bus.din_eop) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         code_q    <= E_NONE;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         b_rdy_q   <= 1'b0;
         busy_q    <= 1'b0;
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         b_rdy_q <= b_rdy_d;
         busy_q  <= (state_d != IDLE);
         if (ok_d && (pkt_cnt_q != '1))  pkt_cnt_q <= pkt_cnt_q + 1'b1;
         if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign bus.b_rdy = b_rdy_q;
   assign pkt_ok    = ok_q;
   assign pkt_err   = err_q;
   assign err_code  = code_q;
   assign pkt_cnt   = pkt_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign busy      = busy_q;
endmodule
